// File: rtl/tb_intr_pkg.sv
// Shared definitions for the TramelBlaze port-mapped interrupt generator.
// Port address defaults, FSM state encoding, CTRL bit indices and status field positions.
package tb_intr_pkg;

  localparam logic [15:0] PERIOD_PORT_DEF = 16'h0001;
  localparam logic [15:0] CTRL_PORT_DEF   = 16'h0002;
  localparam logic [15:0] STATUS_PORT_DEF = 16'h0003;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2
  } state_t;

  localparam int EN_BIT  = 0;
  localparam int CLR_BIT = 1;

  localparam int ST_EN_BIT     = 0;
  localparam int ST_IRQ_BIT    = 1;
  localparam int ST_OVR_BIT    = 2;
  localparam int ST_MISSED_LSB = 8;
  localparam int MISSED_W      = 8;

  function automatic logic [MISSED_W-1:0] sat_inc(input logic [MISSED_W-1:0] v);
    return (v == {MISSED_W{1'b1}}) ? v : v + MISSED_W'(1);
  endfunction

endpackage

// File: rtl/tb_intr_timer.sv
// Period timer: counts 0..period while run, pulses tc on the cycle counter==period.
// Latency: tc is combinational from the counter; clr or !run zeroes the counter on the next edge.
module tb_intr_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc    = run && !clr && (cnt_q == period);
    cnt_d = cnt_q + CNT_W'(1);
    // Wrapping to zero on terminal count keeps the interval at exactly period+1 cycles.
    if (!run || clr || tc) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tb_intr_gen.sv
// Port-mapped periodic interrupt source; INTERRUPT held until INTERRUPT_ACK, overruns flagged in status.
// Writes act on the strobed edge, reads are combinational. Macro TB_INTR_MISSED_EN adds the MISSED counter.
module tb_intr_gen
  import tb_intr_pkg::*;
#(
  parameter int               CNT_W       = 16,
  parameter logic [CNT_W-1:0] PERIOD_RST  = CNT_W'(99),
  parameter logic [15:0]      PERIOD_PORT = PERIOD_PORT_DEF,
  parameter logic [15:0]      CTRL_PORT   = CTRL_PORT_DEF,
  parameter logic [15:0]      STATUS_PORT = STATUS_PORT_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] PORT_ID,
  input  logic [15:0] OUT_PORT,
  input  logic        WRITE_STROBE,
  input  logic        READ_STROBE,
  input  logic        INTERRUPT_ACK,
  output logic        INTERRUPT,
  output logic [15:0] RD_DATA
);

  logic [CNT_W-1:0]    period_q, period_d;
  logic                en_q, en_d;
  logic                irq_q, irq_d;
  logic                ovr_q, ovr_d;
  state_t              state_q, state_d;
  logic                wr_period, wr_ctrl, clr_req, overrun, tc;
  logic [MISSED_W-1:0] missed;

  assign wr_period = WRITE_STROBE && (PORT_ID == PERIOD_PORT);
  assign wr_ctrl   = WRITE_STROBE && (PORT_ID == CTRL_PORT);
  assign clr_req   = wr_ctrl && OUT_PORT[CLR_BIT];

  tb_intr_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (CLK),
    .rst    (RESET),
    .run    (en_q),
    .clr    (wr_period),
    .period (period_q),
    .tc     (tc)
  );

  always_comb begin
    period_d = wr_period ? OUT_PORT[CNT_W-1:0] : period_q;
    en_d     = wr_ctrl ? OUT_PORT[EN_BIT] : en_q;
    state_d  = state_q;
    irq_d    = irq_q;
    overrun  = 1'b0;
    if (!en_q) begin
      state_d = IDLE;
      irq_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, COUNT: begin
          state_d = tc ? REQ : COUNT;
          irq_d   = tc;
        end
        REQ: begin
          // A fresh expiry outranks a simultaneous acknowledge.
          if (tc) begin
            irq_d   = 1'b1;
            overrun = !INTERRUPT_ACK;
          end else if (INTERRUPT_ACK) begin
            state_d = COUNT;
            irq_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      endcase
    end
    ovr_d = ovr_q;
    if (clr_req) ovr_d = 1'b0;
    if (overrun) ovr_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      period_q <= PERIOD_RST;
      en_q     <= 1'b0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
      state_q  <= IDLE;
    end else begin
      period_q <= period_d;
      en_q     <= en_d;
      irq_q    <= irq_d;
      ovr_q    <= ovr_d;
      state_q  <= state_d;
    end
  end

`ifdef TB_INTR_MISSED_EN
  logic [MISSED_W-1:0] missed_q, missed_d;
  logic                missed_clr;

  assign missed_clr = clr_req || (READ_STROBE && (PORT_ID == STATUS_PORT));

  always_comb begin
    missed_d = missed_clr ? '0 : missed_q;
    if (overrun) missed_d = sat_inc(missed_d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) missed_q <= '0;
    else       missed_q <= missed_d;
  end

  assign missed = missed_q;
`else
  logic unused_read_strobe;
  assign unused_read_strobe = READ_STROBE;
  assign missed             = '0;
`endif

  always_comb begin
    RD_DATA = '0;
    if (PORT_ID == PERIOD_PORT) begin
      RD_DATA = 16'(period_q);
    end else if (PORT_ID == CTRL_PORT) begin
      RD_DATA[EN_BIT] = en_q;
    end else if (PORT_ID == STATUS_PORT) begin
      RD_DATA[ST_MISSED_LSB +: MISSED_W] = missed;
      RD_DATA[ST_OVR_BIT]                = ovr_q;
      RD_DATA[ST_IRQ_BIT]                = irq_q;
      RD_DATA[ST_EN_BIT]                 = en_q;
    end
  end

  assign INTERRUPT = irq_q;

endmodule

// File: tb/tb_tb_intr_gen.sv
// Self-checking bench for tb_intr_gen: cycle vector table plus hand sequences for disable, reset and P=0.
// Works with or without TB_INTR_MISSED_EN; the MISSED field is expected as zero when the macro is undefined.
module tb_tb_intr_gen;

  localparam logic [15:0] P_PER = 16'h0001;
  localparam logic [15:0] P_CTL = 16'h0002;
  localparam logic [15:0] P_STS = 16'h0003;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] PORT_ID = 16'h0000;
  logic [15:0] OUT_PORT = 16'h0000;
  logic        WRITE_STROBE = 1'b0;
  logic        READ_STROBE = 1'b0;
  logic        INTERRUPT_ACK = 1'b0;
  logic        INTERRUPT;
  logic [15:0] RD_DATA;

  int checks = 0;
  int failures = 0;

  tb_intr_gen dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PORT_ID       (PORT_ID),
    .OUT_PORT      (OUT_PORT),
    .WRITE_STROBE  (WRITE_STROBE),
    .READ_STROBE   (READ_STROBE),
    .INTERRUPT_ACK (INTERRUPT_ACK),
    .INTERRUPT     (INTERRUPT),
    .RD_DATA       (RD_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] port;
    logic        wr;
    logic [15:0] wdata;
    logic        ack;
    int          n;
    logic        exp_irq;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] st(input int m, input bit ovr, input bit irq, input bit en);
    logic [7:0] mf;
    mf = 8'(m);
`ifndef TB_INTR_MISSED_EN
    mf = 8'h00;
`endif
    return {mf, 5'b0, ovr, irq, en};
  endfunction

  function automatic vec_t mk(input logic [15:0] port, input logic wr, input logic [15:0] wdata,
                              input logic ack, input int n, input logic exp_irq, input logic [15:0] exp_rd);
    vec_t v;
    v.port = port; v.wr = wr; v.wdata = wdata; v.ack = ack;
    v.n = n; v.exp_irq = exp_irq; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wr(input logic [15:0] port, input logic [15:0] data);
    PORT_ID = port;
    OUT_PORT = data;
    WRITE_STROBE = 1'b1;
    tick();
    WRITE_STROBE = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [15:0] port, input logic [15:0] exp);
    PORT_ID = port;
    #1;
    check(name, RD_DATA, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit got;

    // Vector table: each entry applies its inputs for n cycles and checks after every edge.
    tbl.push_back(mk(P_PER, 0, 0, 0, 1, 0, 16'd99));
    tbl.push_back(mk(P_STS, 0, 0, 0, 1, 0, 16'h0000));
    tbl.push_back(mk(P_PER, 1, 9, 0, 1, 0, 16'd9));
    tbl.push_back(mk(P_CTL, 1, 1, 0, 1, 0, 16'h0001));
    tbl.push_back(mk(P_STS, 0, 0, 0, 9, 0, st(0, 0, 0, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 0, 1, 1, st(0, 0, 1, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 0, 2, 1, st(0, 0, 1, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 1, 1, 0, st(0, 0, 0, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 0, 6, 0, st(0, 0, 0, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 0, 1, 1, st(0, 0, 1, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 1, 1, 0, st(0, 0, 0, 1)));
    tbl.push_back(mk(P_CTL, 1, 0, 0, 1, 0, 16'h0000));
    tbl.push_back(mk(P_STS, 0, 0, 0, 1, 0, st(0, 0, 0, 0)));
    tbl.push_back(mk(P_PER, 1, 4, 0, 1, 0, 16'd4));
    tbl.push_back(mk(P_CTL, 1, 1, 0, 1, 0, 16'h0001));
    tbl.push_back(mk(P_STS, 0, 0, 0, 4, 0, st(0, 0, 0, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 0, 1, 1, st(0, 0, 1, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 0, 4, 1, st(0, 0, 1, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 0, 1, 1, st(1, 1, 1, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 0, 4, 1, st(1, 1, 1, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 0, 1, 1, st(2, 1, 1, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 0, 2, 1, st(2, 1, 1, 1)));
    tbl.push_back(mk(P_CTL, 1, 3, 0, 1, 1, 16'h0001));
    tbl.push_back(mk(P_STS, 0, 0, 0, 1, 1, st(0, 0, 1, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 1, 1, 1, st(0, 0, 1, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 1, 1, 0, st(0, 0, 0, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 1, 3, 0, st(0, 0, 0, 1)));
    tbl.push_back(mk(P_STS, 0, 0, 0, 1, 1, st(0, 0, 1, 1)));
    tbl.push_back(mk(16'h0007, 0, 0, 0, 1, 1, 16'h0000));
    tbl.push_back(mk(P_STS, 0, 0, 0, 3, 1, st(0, 0, 1, 1)));
    tbl.push_back(mk(P_CTL, 1, 3, 0, 1, 1, 16'h0001));
    tbl.push_back(mk(P_STS, 0, 0, 0, 1, 1, st(1, 1, 1, 1)));

    RESET = 1'b1;
    tick();
    tick();
    check("reset_irq", 16'(INTERRUPT), 16'h0000);
    RESET = 1'b0;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        PORT_ID = tbl[i].port;
        OUT_PORT = tbl[i].wdata;
        WRITE_STROBE = tbl[i].wr && (k == 0);
        INTERRUPT_ACK = tbl[i].ack;
        tick();
        check($sformatf("vec%0d_c%0d_irq", i, k), 16'(INTERRUPT), 16'(tbl[i].exp_irq));
        check($sformatf("vec%0d_c%0d_rd", i, k), RD_DATA, tbl[i].exp_rd);
      end
      WRITE_STROBE = 1'b0;
      INTERRUPT_ACK = 1'b0;
    end

    // Disable during REQ: request drops, counts are kept.
    wr(P_CTL, 16'h0000);
    PORT_ID = P_STS;
    tick();
    check("disable_irq", 16'(INTERRUPT), 16'h0000);
    check("disable_status", RD_DATA, st(1, 1, 0, 0));

    // Re-enable: first request P+1 = 5 cycles after the EN write edge.
    wr(P_CTL, 16'h0001);
    cnt = 0;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      tick();
      cnt++;
      if (INTERRUPT) got = 1'b1;
    end
    check("reenable_latency", 16'(cnt), 16'd5);

    // Reset while a request is pending.
    RESET = 1'b1;
    tick();
    check("reset_mid_req_irq", 16'(INTERRUPT), 16'h0000);
    RESET = 1'b0;
    rd_check("reset_mid_req_period", P_PER, 16'd99);
    rd_check("reset_mid_req_status", P_STS, 16'h0000);
    rd_check("reset_mid_req_ctrl", P_CTL, 16'h0000);
    repeat (8) tick();
    check("reset_stays_idle_irq", 16'(INTERRUPT), 16'h0000);

    // P=0 with ACK held: continuous request, never an overrun.
    INTERRUPT_ACK = 1'b1;
    wr(P_PER, 16'h0000);
    wr(P_CTL, 16'h0001);
    PORT_ID = P_STS;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("p0_ack_c%0d_irq", k), 16'(INTERRUPT), 16'h0001);
      check($sformatf("p0_ack_c%0d_status", k), RD_DATA, st(0, 0, 1, 1));
    end
    INTERRUPT_ACK = 1'b0;
    tick();
    check("p0_noack_status", RD_DATA, st(1, 1, 1, 1));
    wr(P_CTL, 16'h0000);
    PORT_ID = P_STS;
    tick();
    check("p0_disable_irq", 16'(INTERRUPT), 16'h0000);
    check("p0_disable_status", RD_DATA, st(2, 1, 0, 0));

    // Status read with READ_STROBE clears MISSED only, OVR stays.
    READ_STROBE = 1'b1;
    tick();
    READ_STROBE = 1'b0;
    check("clear_on_read_status", RD_DATA, st(0, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
